// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the byte-serial ALU sequencer.
// ALU control codes, slice operation codes, FSM states, decoded controls.
package alu_seq_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;
    localparam logic [1:0] OP_LESS = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic [1:0] op;
        logic       cin0;
        logic       is_slt;
        logic       is_arith;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/alu8.sv
// 8-bit ALU slice with group propagate/generate outputs.
// G is the carry-out with cin=0; P is set when every bit propagates.
module alu8
    import alu_seq_pkg::*;
(
    input  logic [7:0] src1,
    input  logic [7:0] src2,
    input  logic       less,
    input  logic       A_invert,
    input  logic       B_invert,
    input  logic       cin,
    input  logic [1:0] operation,
    output logic [7:0] result,
    output logic       P,
    output logic       G
);

    logic [7:0] a;
    logic [7:0] b;
    logic [8:0] gen;
    logic [8:0] sum;

    // Operand conditioning, sum and group carry terms
    always_comb begin
        a   = A_invert ? ~src1 : src1;
        b   = B_invert ? ~src2 : src2;
        gen = {1'b0, a} + {1'b0, b};
        sum = {1'b0, a} + {1'b0, b} + {8'b0, cin};
        P   = &(a ^ b);
        G   = gen[8];
        case (operation)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_ADD:  result = sum[7:0];
            default: result = {7'b0, less};
        endcase
    end

endmodule

// File: rtl/alu_byte_seq_decode.sv
// ALU control code to slice control decoder.
// Unknown codes run the slice as AND and are flagged illegal.
module alu_ctrl_decode
    import alu_seq_pkg::*;
(
    input  logic [3:0] alu_control,
    output ctrl_t      ctrl
);

    // Pure table lookup; every field given a value on every path
    always_comb begin
        ctrl = '{a_inv: 1'b0, b_inv: 1'b0, op: OP_AND, cin0: 1'b0,
                 is_slt: 1'b0, is_arith: 1'b0, illegal: 1'b0};
        case (alu_control)
            ALU_AND: ctrl.op = OP_AND;
            ALU_OR:  ctrl.op = OP_OR;
            ALU_ADD: begin
                ctrl.op       = OP_ADD;
                ctrl.is_arith = 1'b1;
            end
            ALU_SUB: begin
                ctrl.op       = OP_ADD;
                ctrl.b_inv    = 1'b1;
                ctrl.cin0     = 1'b1;
                ctrl.is_arith = 1'b1;
            end
            ALU_SLT: begin
                ctrl.op       = OP_ADD;
                ctrl.b_inv    = 1'b1;
                ctrl.cin0     = 1'b1;
                ctrl.is_arith = 1'b1;
                ctrl.is_slt   = 1'b1;
            end
            ALU_NOR: begin
                ctrl.op    = OP_AND;
                ctrl.a_inv = 1'b1;
                ctrl.b_inv = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_byte_seq.sv
// 32-bit ALU built by running one 8-bit slice over NUM_BYTES cycles.
// LSB byte first; carry chained through a register from slice P/G.
module alu_byte_seq
    import alu_seq_pkg::*;
#(
    parameter int NUM_BYTES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [8*NUM_BYTES-1:0] src1,
    input  logic [8*NUM_BYTES-1:0] src2,
    input  logic [3:0]             ALU_control,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [8*NUM_BYTES-1:0] result,
    output logic                   zero,
    output logic                   cout,
    output logic                   overflow,
    output logic [7:0]             slice_src1,
    output logic [7:0]             slice_src2,
    output logic                   slice_less,
    output logic                   slice_A_invert,
    output logic                   slice_B_invert,
    output logic                   slice_cin,
    output logic [1:0]             slice_operation,
    input  logic [7:0]             slice_result,
    input  logic                   slice_P,
    input  logic                   slice_G
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int IW = $clog2(NUM_BYTES);
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic          carry_q, carry_d;
    logic [W-1:0]  res_q, res_d;
    logic          zero_q, zero_d;
    logic          cout_q, cout_d;
    logic          ovf_q, ovf_d;

    ctrl_t         dec;
    logic          c_out;
    logic          ovf_raw;
    logic [W-1:0]  res_next;

    alu_ctrl_decode u_dec (
        .alu_control (ALU_control),
        .ctrl        (dec)
    );

    assign in_ready        = (state_q == S_IDLE);
    assign out_valid       = (state_q == S_DONE);
    assign result          = res_q;
    assign zero            = zero_q;
    assign cout            = cout_q;
    assign overflow        = ovf_q;
    assign slice_src1      = a_q[{idx_q, 3'b000} +: 8];
    assign slice_src2      = b_q[{idx_q, 3'b000} +: 8];
    assign slice_less      = 1'b0;
    assign slice_A_invert  = ctrl_q.a_inv;
    assign slice_B_invert  = ctrl_q.b_inv;
    assign slice_cin       = carry_q;
    assign slice_operation = ctrl_q.op;

    // Sequencer: accept, walk the bytes, finalize flags, hold result
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        carry_d  = carry_q;
        res_d    = res_q;
        zero_d   = zero_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        c_out    = slice_G | (slice_P & carry_q);
        ovf_raw  = a_q[W-1] ^ (b_q[W-1] ^ ctrl_q.b_inv)
                 ^ slice_result[7] ^ c_out;
        res_next = res_q;
        res_next[{idx_q, 3'b000} +: 8] = slice_result;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = src1;
                    b_d     = src2;
                    ctrl_d  = dec;
                    idx_d   = '0;
                    carry_d = dec.cin0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                res_d   = res_next;
                carry_d = c_out;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = S_DONE;
                    if (ctrl_q.illegal)
                        res_d = '0;
                    else if (ctrl_q.is_slt)
                        res_d = {{(W-1){1'b0}}, slice_result[7] ^ ovf_raw};
                    zero_d = (res_d == '0);
                    cout_d = ctrl_q.is_arith & ~ctrl_q.is_slt & c_out;
                    ovf_d  = ctrl_q.is_arith & ~ctrl_q.is_slt & ovf_raw;
                end
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_alu_byte_seq.sv
// Directed bench for alu_byte_seq wired to the alu8 slice.
// Vector table plus backpressure and mid-run reset sequences.
module tb_alu_byte_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALU_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic [7:0]  s_src1;
    logic [7:0]  s_src2;
    logic        s_less;
    logic        s_ainv;
    logic        s_binv;
    logic        s_cin;
    logic [1:0]  s_op;
    logic [7:0]  s_res;
    logic        s_p;
    logic        s_g;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    alu_byte_seq #(.NUM_BYTES(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .src1(src1), .src2(src2), .ALU_control(ALU_control),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .cout(cout), .overflow(overflow),
        .slice_src1(s_src1), .slice_src2(s_src2), .slice_less(s_less),
        .slice_A_invert(s_ainv), .slice_B_invert(s_binv),
        .slice_cin(s_cin), .slice_operation(s_op),
        .slice_result(s_res), .slice_P(s_p), .slice_G(s_g)
    );

    alu8 u_slice (
        .src1(s_src1), .src2(s_src2), .less(s_less),
        .A_invert(s_ainv), .B_invert(s_binv), .cin(s_cin),
        .operation(s_op), .result(s_res), .P(s_p), .G(s_g)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Issue one op; returns once out_valid seen (or budget expires)
    task automatic do_op(input string name, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        @(negedge clk);
        in_valid    = 1'b1;
        ALU_control = op;
        src1        = a;
        src2        = b;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        src1        = 32'hDEAD_BEEF;
        src2        = 32'h1234_5678;
        ALU_control = 4'b0000;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 32'(lat), 32'd4);
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        do_op(v.name, v.op, v.a, v.b, lat);
        chk({v.name, " result"}, result, v.res);
        chk({v.name, " zero"}, 32'(zero), 32'(v.z));
        chk({v.name, " cout"}, 32'(cout), 32'(v.c));
        chk({v.name, " ovf"}, 32'(overflow), 32'(v.v));
    endtask

    initial begin
        int lat;
        vecs[0]  = '{"add_ovf",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1};
        vecs[1]  = '{"sub_eq",   4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0};
        vecs[2]  = '{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0};
        vecs[3]  = '{"slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0};
        vecs[4]  = '{"slt_ovf",  4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1, 0, 0};
        vecs[5]  = '{"nor",      4'b1100, 32'h0F0F0000, 32'h00F0F000, 32'hF0000FFF, 0, 0, 0};
        vecs[6]  = '{"or",       4'b0001, 32'h12340000, 32'h00005678, 32'h12345678, 0, 0, 0};
        vecs[7]  = '{"and",      4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0};
        vecs[8]  = '{"illegal",  4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 0, 0};
        vecs[9]  = '{"sub_neg",  4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0};
        vecs[10] = '{"sub_ovf",  4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 0, 1, 1};
        vecs[11] = '{"add_chain",4'b0010, 32'h000000FF, 32'h00000001, 32'h00000100, 0, 0, 0};
        vecs[12] = '{"slt_eq",   4'b0111, 32'h00000005, 32'h00000005, 32'h00000000, 1, 0, 0};
        vecs[13] = '{"slt_nn",   4'b0111, 32'hFFFFFFFB, 32'hFFFFFFFD, 32'h00000001, 0, 0, 0};
        vecs[14] = '{"add_mid",  4'b0010, 32'h00FF8000, 32'h00008000, 32'h01000000, 0, 0, 0};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        src1 = '0;
        src2 = '0;
        ALU_control = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst result", result, 32'd0);
        chk("rst zero", 32'(zero), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        chk("rst slice_src1", 32'(s_src1), 32'd0);

        for (int i = 0; i < 15; i++)
            run_vec(vecs[i]);

        @(negedge clk);
        chk("idle in_ready", 32'(in_ready), 32'd1);
        chk("idle out_valid", 32'(out_valid), 32'd0);

        out_ready = 1'b0;
        do_op("bp", 4'b0010, 32'd1, 32'd2, lat);
        chk("bp result", result, 32'd3);
        for (int i = 0; i < 3; i++) begin
            in_valid    = 1'b1;
            ALU_control = 4'b0001;
            src1        = 32'hFFFF_0000;
            src2        = 32'h0000_FFFF;
            @(negedge clk);
            chk("bp out_valid", 32'(out_valid), 32'd1);
            chk("bp hold", result, 32'd3);
            chk("bp in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp release valid", 32'(out_valid), 32'd0);
        chk("bp release ready", 32'(in_ready), 32'd1);
        chk("bp result kept", result, 32'd3);

        in_valid    = 1'b1;
        ALU_control = 4'b0010;
        src1        = 32'h0101_0101;
        src2        = 32'h0101_0101;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rr mid result", result, 32'h0000_0202);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr out_valid", 32'(out_valid), 32'd0);
        chk("rr in_ready", 32'(in_ready), 32'd1);
        chk("rr result", result, 32'd0);
        repeat (5) @(negedge clk);
        chk("rr no output", 32'(out_valid), 32'd0);

        run_vec('{"post_rst", 4'b0010, 32'd3, 32'd4, 32'd7, 0, 0, 0});

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_byte_seq.md
Name: alu_byte_seq

Overview:
Multi-cycle controller that computes a 32-bit ALU operation by time-sharing one external 8-bit ALU slice (8-bit ALU with CLA, P/G group outputs) over NUM_BYTES cycles, LSB byte first. It decodes the 4-bit ALU control code into slice controls, chains the carry between bytes from the slice's P/G outputs, and assembles the result, SLT flag, zero, carry-out and overflow. It sits between the issue logic (valid/ready handshake) and the shared 8-bit slice.

Parameters:
NUM_BYTES, 4, number of byte passes; operand width W = 8*NUM_BYTES (must be >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  block can accept a request (high only in IDLE)
src1  input  W  operand A
src2  input  W  operand B
ALU_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR
out_valid  output  1  result valid, held until out_ready
out_ready  input  1  consumer accepts result
result  output  W  operation result
zero  output  1  result == 0
cout  output  1  carry out of MSB (ADD/SUB only, else 0)
overflow  output  1  signed overflow (ADD/SUB only, else 0)
slice_src1  output  8  byte of A to slice
slice_src2  output  8  byte of B to slice
slice_less  output  1  tied 0 (SLT resolved in this block)
slice_A_invert  output  1  slice A invert
slice_B_invert  output  1  slice B invert
slice_cin  output  1  carry into current byte
slice_operation  output  2  00 AND, 01 OR, 10 ADD, 11 LESS (never driven 11)
slice_result  input  8  slice byte result (combinational from slice_* outputs)
slice_P  input  1  slice group propagate
slice_G  input  1  slice group generate

Behaviour:
- Reset and idle: rst forces IDLE; in_ready=1, out_valid=0, result=0, zero=0 (register, cleared), cout=0, overflow=0, byte index 0, carry register 0. Reset mid-RUN or mid-DONE aborts; no output produced.
- FSM IDLE -> RUN on in_valid&&in_ready: latch src1, src2, decoded controls; byte index=0; carry register = 1 for SUB/SLT, else 0.
- Decode: AND {Ainv=0,Binv=0,op=00}; OR {0,0,01}; ADD {0,0,10}; SUB/SLT {0,1,10}; NOR {1,1,00}. Unrecognized code: slice driven as AND, final result forced 0, cout/overflow 0; same latency.
- RUN (NUM_BYTES cycles): slice_src1/slice_src2 = byte[idx] of latched operands; slice_cin = carry register; controls constant. Each cycle: result byte[idx] <= slice_result; carry <= slice_G | (slice_P & carry); idx++. After idx = NUM_BYTES-1 -> DONE.
- Flags computed on last RUN cycle: bm = B[W-1]^Binv; c_in_msb = A[W-1]^bm^slice_result[7]; c_out = G|(P&carry); overflow = c_in_msb ^ c_out.
- SLT: result = {(W-1)'b0, sum[W-1]^overflow}; cout and overflow reported 0.
- DONE: out_valid=1, outputs stable; in_ready=0. On out_ready -> IDLE same cycle as handshake; in_ready rises next cycle. No pipelining; one request outstanding.
- Latency: request accepted at edge N; out_valid high from edge N+NUM_BYTES (DONE reached); throughput at best one op per NUM_BYTES+2 cycles.
- slice_* outputs in IDLE/DONE: byte 0 of last latched operands, controls held; content is don't-care to the slice but must be X-free after reset.
- in_valid while not in IDLE ignored; src/ALU_control only sampled at acceptance.

Decomposition:
- Package alu_seq_pkg: ALU_control code constants, slice operation constants (OP_AND/OP_OR/OP_ADD/OP_LESS), FSM state enum, decoded-control struct {a_inv, b_inv, op, cin0, is_slt, is_arith, illegal}.
- One sub-module natural: alu_ctrl_decode (combinational ALU_control -> decoded-control struct). Bench instantiates alu_byte_seq with the real alu8 slice.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> result 0x80000000, overflow 1, cout 0, zero 0; out_valid exactly 4 cycles after accept edge.
- SUB 0x00000005 - 0x00000005 -> result 0, zero 1, cout 1, overflow 0; ADD 0xFFFFFFFF+1 -> 0, cout 1, overflow 0.
- SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLT 0x7FFFFFFF vs 0x80000000 -> 0 (overflow path); both cout/overflow 0.
- NOR 0x0F0F0000, 0x00F0F000 -> 0xF0000FFF; OR/AND spot values; illegal code 0101 -> result 0, zero 1.
- Backpressure: out_ready low 3 cycles -> out_valid and result stable, in_ready 0, new in_valid ignored; then accepted handshake returns to IDLE.
- rst asserted at RUN idx=2 -> next cycle IDLE, out_valid 0, result 0; following ADD 3+4 -> 7 with normal latency.
